// File: rtl/bus_arbiter_2m.sv
// Two-master, one-slave round-robin bus arbiter with per-grant slave timeout.
// Master 0 (core load/store) waiting for the bus raises hold_core to stall the pipeline.
module bus_arbiter_2m #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              s_req,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ack,
    output logic              hold_core,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t            state, state_nxt;
    logic              last_grant, last_grant_nxt;
    logic [7:0]        tmo_cnt, tmo_cnt_nxt;
    logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

    logic gnt0, gnt1, busy, cur_req, timed_out, done_err, abort;

    assign gnt0      = (state == GNT0);
    assign gnt1      = (state == GNT1);
    assign busy      = gnt0 | gnt1;
    assign cur_req   = (gnt0 & m0_req) | (gnt1 & m1_req);
    assign timed_out = busy & (tmo_cnt == 8'(TIMEOUT));
    // A slave ack in the timeout cycle wins over the error.
    assign done_err  = timed_out & cur_req & ~s_ack;
    assign abort     = busy & ~cur_req & ~s_ack;

    // Slave side follows the granted master only; the other master is masked.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        s_req   = 1'b0;
        s_we    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        if (gnt0) begin
            s_req   = m0_req & ~timed_out;
            s_we    = m0_we;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
        end else if (gnt1) begin
            s_req   = m1_req & ~timed_out;
            s_we    = m1_we;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
        end
    end

    assign m0_ack   = gnt0 & (s_ack | done_err);
    assign m1_ack   = gnt1 & (s_ack | done_err);
    assign m0_err   = gnt0 & done_err;
    assign m1_err   = gnt1 & done_err;
    assign m0_rdata = (gnt0 & s_ack) ? s_rdata : m0_rdata_q;
    assign m1_rdata = (gnt1 & s_ack) ? s_rdata : m1_rdata_q;
    assign grant    = {gnt1, gnt0};
    // Gated by rstn so the stall releases the instant reset asserts.
    assign hold_core = rstn & m0_req & ~m0_ack;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        tmo_cnt_nxt    = tmo_cnt;
        case (state)
            IDLE: begin
                tmo_cnt_nxt = '0;
                if (m0_req && m1_req) state_nxt = last_grant ? GNT0 : GNT1;
                else if (m0_req)      state_nxt = GNT0;
                else if (m1_req)      state_nxt = GNT1;
            end
            GNT0, GNT1: begin
                if (s_ack || done_err || abort) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = gnt1;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            tmo_cnt    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            tmo_cnt    <= tmo_cnt_nxt;
            if (gnt0 && s_ack) m0_rdata_q <= s_rdata;
            if (gnt1 && s_ack) m1_rdata_q <= s_rdata;
        end
    end

endmodule
